// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common: project-wide basic types shared by the pipeline blocks.
//   word_t : 64-bit machine word (addresses, data)
// -----------------------------------------------------------------------------
package common;

  typedef logic [63:0] word_t;

endpackage : common

// File: rtl/pipes_pkg.sv
// -----------------------------------------------------------------------------
// pipes: shared types and constants for the pipeline stall/flush sequencer.
//   pipe_ctrl_state_t : sequencer FSM states (RUN, REDIR_WAIT, MDU)
//   pipe_ctrl_t       : bundle of per-register hold/bubble controls + pc_load
//   MDU_TIMEOUT_DEF   : default MDU watchdog limit in cycles
//   applyFlushPriority: resolves stall/flush conflicts on the same register
// -----------------------------------------------------------------------------
package pipes;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    MDU        = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic stallPc;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushM;
    logic flushW;
    logic pcLoad;
  } pipe_ctrl_t;

  localparam int MDU_TIMEOUT_DEF = 64;

  // A register that loads a bubble has nothing worth holding, so flush wins
  // and the matching stall is dropped. PC has no flush and W has no stall.
  function automatic pipe_ctrl_t applyFlushPriority(input pipe_ctrl_t c);
    pipe_ctrl_t r;
    r        = c;
    r.stallD = c.stallD & ~c.flushD;
    r.stallE = c.stallE & ~c.flushE;
    r.stallM = c.stallM & ~c.flushM;
    return r;
  endfunction

endpackage : pipes

// File: rtl/pipe_ctrl_hazard_ldu.sv
// -----------------------------------------------------------------------------
// hazard_ldu: combinational load-use comparator. Flags when the instruction in
// D reads a register that the load currently in E has not produced yet.
// Register x0 is hard-wired zero and never creates a dependency.
// Kept standalone so the forwarding path can reuse the same comparison.
//
// Ports:
//   memRead  in  1  instruction in E is a load
//   eDst     in  5  destination register of E
//   rs1, rs2 in  5  source registers of D
//   useRs1/2 in  1  D actually reads rs1/rs2
//   loadUse  out 1  load-use hazard present
// -----------------------------------------------------------------------------
module hazard_ldu (
  input  logic       memRead,
  input  logic [4:0] eDst,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       useRs1,
  input  logic       useRs2,
  output logic       loadUse
);

  logic hitRs1;
  logic hitRs2;

  assign hitRs1  = useRs1 && (rs1 == eDst);
  assign hitRs2  = useRs2 && (rs2 == eDst);
  assign loadUse = memRead && (eDst != 5'd0) && (hitRs1 || hitRs2);

endmodule : hazard_ldu

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W).
// Covers the hazards forwarding cannot: load-use, taken branches/jumps
// resolved in E, instruction/data bus waits and multi-cycle MDU operations.
// All stall/flush/pc_load outputs are combinational from inputs and state.
//
// Optional build macro PIPE_PERF_EN adds CNT_W-bit saturating perf counters
// (cnt_loaduse, cnt_redirect, cnt_mem_stall, cnt_mdu_stall).
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   ifetch_busy           F has no valid instruction this cycle
//   dmem_busy             M-stage data access outstanding
//   e_memread, e_dst      load flag / destination register of E
//   d_rs1/2, d_use_rs1/2  source registers of D and their use flags
//   redirect_valid/pc     taken branch/jump resolved in E and its target
//   mdu_start, mdu_done   multi-cycle MDU issue / result valid
//   stall_pc/d/e/m        register holds its value at the next edge
//   flush_d/e/m/w         register loads a bubble at the next edge
//   pc_load, pc_target    PC loads pc_target at the next edge
//   err_mdu_timeout       sticky: MDU wait hit MDU_TIMEOUT cycles
//   busy_state            current FSM state (debug)
// -----------------------------------------------------------------------------
module pipe_ctrl
  import common::*;
  import pipes::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifetch_busy,
  input  logic        dmem_busy,
  input  logic        e_memread,
  input  logic [4:0]  e_dst,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_use_rs1,
  input  logic        d_use_rs2,
  input  logic        redirect_valid,
  input  word_t       redirect_pc,
  input  logic        mdu_start,
  input  logic        mdu_done,
  output logic        stall_pc,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        pc_load,
  output word_t       pc_target,
  output logic        err_mdu_timeout,
  output logic [1:0]  busy_state
`ifdef PIPE_PERF_EN
  , output logic [CNT_W-1:0] cnt_loaduse
  , output logic [CNT_W-1:0] cnt_redirect
  , output logic [CNT_W-1:0] cnt_mem_stall
  , output logic [CNT_W-1:0] cnt_mdu_stall
`endif
);

  localparam int TO_W = $clog2(MDU_TIMEOUT + 1);

  pipe_ctrl_state_t stateQ;
  pipe_ctrl_state_t stateD;
  pipe_ctrl_t       ctrlRaw;
  pipe_ctrl_t       ctrl;
  word_t            targetQ;
  logic [TO_W-1:0]  mduCnt;
  logic             errQ;
  logic             loadUse;
  logic             acceptRedir;    // redirect accepted in RUN this cycle
  logic             loadUseBubble;  // load-use bubble inserted this cycle

  hazard_ldu u_ldu (
    .memRead (e_memread),
    .eDst    (e_dst),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .useRs1  (d_use_rs1),
    .useRs2  (d_use_rs2),
    .loadUse (loadUse)
  );

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle controls.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    ctrlRaw       = '0;
    stateD        = stateQ;
    acceptRedir   = 1'b0;
    loadUseBubble = 1'b0;

    case (stateQ)
      RUN: begin
        if (dmem_busy) begin
          // Full freeze: E holds, so a pending redirect/mdu_start re-presents.
          ctrlRaw.stallPc = 1'b1;
          ctrlRaw.stallD  = 1'b1;
          ctrlRaw.stallE  = 1'b1;
          ctrlRaw.stallM  = 1'b1;
          ctrlRaw.flushW  = 1'b1;
        end else if (mdu_start) begin
          ctrlRaw.stallPc = 1'b1;
          ctrlRaw.stallD  = 1'b1;
          ctrlRaw.stallE  = 1'b1;
          ctrlRaw.flushM  = 1'b1;
          stateD          = MDU;
        end else if (redirect_valid) begin
          // Checked ahead of load-use: D is squashed, so its hazard is moot.
          ctrlRaw.flushD = 1'b1;
          ctrlRaw.flushE = 1'b1;
          acceptRedir    = 1'b1;
          if (ifetch_busy) begin
            stateD = REDIR_WAIT;
          end else begin
            ctrlRaw.pcLoad = 1'b1;
          end
        end else if (loadUse) begin
          // One bubble suffices: the load moves to M and forwarding takes over.
          ctrlRaw.stallPc = 1'b1;
          ctrlRaw.stallD  = 1'b1;
          ctrlRaw.flushE  = 1'b1;
          loadUseBubble   = 1'b1;
        end else if (ifetch_busy) begin
          ctrlRaw.stallPc = 1'b1;
          ctrlRaw.flushD  = 1'b1;
        end
      end

      REDIR_WAIT: begin
        // Whatever fetch returns belongs to the old path; keep D empty.
        ctrlRaw.flushD = 1'b1;
        if (dmem_busy) begin
          ctrlRaw.stallPc = 1'b1;
          ctrlRaw.stallE  = 1'b1;
          ctrlRaw.stallM  = 1'b1;
          ctrlRaw.flushW  = 1'b1;
        end else if (ifetch_busy) begin
          ctrlRaw.stallPc = 1'b1;
        end else begin
          ctrlRaw.pcLoad = 1'b1;
          stateD         = RUN;
        end
      end

      MDU: begin
        ctrlRaw.stallPc = 1'b1;
        ctrlRaw.stallD  = 1'b1;
        if (mdu_done) begin
          // Release E so the result advances into M at this edge.
          stateD = RUN;
        end else begin
          ctrlRaw.stallE = 1'b1;
          ctrlRaw.flushM = 1'b1;
        end
      end

      default: stateD = RUN;
    endcase
  end

  // Outputs read as idle while reset is held.
  assign ctrl = reset ? pipe_ctrl_t'('0) : applyFlushPriority(ctrlRaw);

  assign stall_pc        = ctrl.stallPc;
  assign stall_d         = ctrl.stallD;
  assign stall_e         = ctrl.stallE;
  assign stall_m         = ctrl.stallM;
  assign flush_d         = ctrl.flushD;
  assign flush_e         = ctrl.flushE;
  assign flush_m         = ctrl.flushM;
  assign flush_w         = ctrl.flushW;
  assign pc_load         = ctrl.pcLoad;
  assign pc_target       = (acceptRedir && !reset) ? redirect_pc : targetQ;
  assign err_mdu_timeout = errQ;
  assign busy_state      = stateQ;

  // ---------------------------------------------------------------------------
  // State, latched redirect target and MDU watchdog.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= RUN;
      targetQ <= '0;
      mduCnt  <= '0;
      errQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (acceptRedir) begin
        targetQ <= redirect_pc;
      end
      if (stateQ != MDU && stateD == MDU) begin
        mduCnt <= '0;
      end else if (stateQ == MDU && mduCnt != TO_W'(MDU_TIMEOUT)) begin
        mduCnt <= mduCnt + TO_W'(1);
      end
      // Counter reaches the limit at this edge; the FSM keeps waiting.
      if (stateQ == MDU && mduCnt == TO_W'(MDU_TIMEOUT - 1)) begin
        errQ <= 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_loaduse   <= '0;
      cnt_redirect  <= '0;
      cnt_mem_stall <= '0;
      cnt_mdu_stall <= '0;
    end else begin
      if (loadUseBubble && cnt_loaduse != CNT_MAX) begin
        cnt_loaduse <= cnt_loaduse + CNT_W'(1);
      end
      if (acceptRedir && cnt_redirect != CNT_MAX) begin
        cnt_redirect <= cnt_redirect + CNT_W'(1);
      end
      if (dmem_busy && cnt_mem_stall != CNT_MAX) begin
        cnt_mem_stall <= cnt_mem_stall + CNT_W'(1);
      end
      if (stateQ == MDU && cnt_mdu_stall != CNT_MAX) begin
        cnt_mdu_stall <= cnt_mdu_stall + CNT_W'(1);
      end
    end
  end
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Inputs change 1 time unit after the rising edge; the combinational outputs
// are compared 1 unit later, well before the next edge.
// Output vector order in checks: {stall_pc, stall_d, stall_e, stall_m,
// flush_d, flush_e, flush_m, flush_w, pc_load}.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifetch_busy;
  logic        dmem_busy;
  logic        e_memread;
  logic [4:0]  e_dst;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic        d_use_rs1;
  logic        d_use_rs2;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mdu_start;
  logic        mdu_done;
  logic        stall_pc, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic        pc_load;
  logic [63:0] pc_target;
  logic        err_mdu_timeout;
  logic [1:0]  busy_state;
`ifdef PIPE_PERF_EN
  logic [31:0] cnt_loaduse, cnt_redirect, cnt_mem_stall, cnt_mdu_stall;
`endif

  int nChecks = 0;
  int nPass   = 0;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MDU  = 2'd2;

  // Expected control vectors.
  localparam logic [8:0] O_IDLE     = 9'b000000000;
  localparam logic [8:0] O_LOADUSE  = 9'b110001000;
  localparam logic [8:0] O_REDIR_LD = 9'b000011001;
  localparam logic [8:0] O_REDIR_BZ = 9'b000011000;
  localparam logic [8:0] O_FETCHWT  = 9'b100010000;
  localparam logic [8:0] O_WAIT_LD  = 9'b000010001;
  localparam logic [8:0] O_MDU      = 9'b111000100;
  localparam logic [8:0] O_MDU_DONE = 9'b110000000;
  localparam logic [8:0] O_FREEZE   = 9'b111100010;
  localparam logic [8:0] O_WAIT_MEM = 9'b101110010;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .ifetch_busy     (ifetch_busy),
    .dmem_busy       (dmem_busy),
    .e_memread       (e_memread),
    .e_dst           (e_dst),
    .d_rs1           (d_rs1),
    .d_rs2           (d_rs2),
    .d_use_rs1       (d_use_rs1),
    .d_use_rs2       (d_use_rs2),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .mdu_start       (mdu_start),
    .mdu_done        (mdu_done),
    .stall_pc        (stall_pc),
    .stall_d         (stall_d),
    .stall_e         (stall_e),
    .stall_m         (stall_m),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .flush_m         (flush_m),
    .flush_w         (flush_w),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .err_mdu_timeout (err_mdu_timeout),
    .busy_state      (busy_state)
`ifdef PIPE_PERF_EN
    , .cnt_loaduse   (cnt_loaduse)
    , .cnt_redirect  (cnt_redirect)
    , .cnt_mem_stall (cnt_mem_stall)
    , .cnt_mdu_stall (cnt_mdu_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] outs();
    return {stall_pc, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_m, flush_w, pc_load};
  endfunction

  task automatic checkCtl(input string tag, input logic [8:0] expOuts, input logic [1:0] expState);
    check({tag, ".ctl"},   64'(outs()),     64'(expOuts));
    check({tag, ".state"}, 64'(busy_state), 64'(expState));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifetch_busy    = 1'b0;
    dmem_busy      = 1'b0;
    e_memread      = 1'b0;
    e_dst          = 5'd0;
    d_rs1          = 5'd0;
    d_rs2          = 5'd0;
    d_use_rs1      = 1'b0;
    d_use_rs2      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    mdu_start      = 1'b0;
    mdu_done       = 1'b0;
  endtask

  task automatic setLoadUse(input logic [4:0] dst);
    e_memread = 1'b1;
    e_dst     = dst;
    d_rs2     = 5'd5;
    d_use_rs2 = 1'b1;
  endtask

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkCtl("reset", O_IDLE, S_RUN);
    check("reset.pc_target", pc_target, 64'h0);
    check("reset.err", 64'(err_mdu_timeout), 64'h0);
`ifdef PIPE_PERF_EN
    check("reset.cnt", 64'(cnt_loaduse | cnt_redirect | cnt_mem_stall | cnt_mdu_stall), 64'h0);
`endif

    // Load-use on rs2: one bubble, then clear.
    tick(); setLoadUse(5'd5); #1;
    checkCtl("ldu.hit", O_LOADUSE, S_RUN);
    tick(); idle(); #1;
    checkCtl("ldu.after", O_IDLE, S_RUN);
    // Destination x0 never stalls.
    tick(); setLoadUse(5'd0); d_rs2 = 5'd0; #1;
    checkCtl("ldu.x0", O_IDLE, S_RUN);
    // rs1 matches but D does not read it.
    tick(); idle(); e_memread = 1'b1; e_dst = 5'd7; d_rs1 = 5'd7; #1;
    checkCtl("ldu.unused", O_IDLE, S_RUN);

    // Redirect with fetch ready.
    tick(); idle(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; #1;
    checkCtl("redir.now", O_REDIR_LD, S_RUN);
    check("redir.now.pc", pc_target, 64'h8000_0100);
    tick(); idle(); #1;
    checkCtl("redir.after", O_IDLE, S_RUN);

    // Redirect beats a same-cycle load-use.
    tick(); setLoadUse(5'd5); redirect_valid = 1'b1; redirect_pc = 64'h1234; #1;
    checkCtl("redir.ldu", O_REDIR_LD, S_RUN);
    check("redir.ldu.pc", pc_target, 64'h1234);

    // Redirect while fetch busy: 3 busy cycles, then load latched target.
    tick(); idle(); ifetch_busy = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h4000_0200; #1;
    checkCtl("rwait.0", O_REDIR_BZ, S_RUN);
    check("rwait.0.pc", pc_target, 64'h4000_0200);
    tick(); idle(); ifetch_busy = 1'b1; redirect_pc = 64'hdead_beef; #1;
    checkCtl("rwait.1", O_FETCHWT, S_WAIT);
    tick(); #1;
    checkCtl("rwait.2", O_FETCHWT, S_WAIT);
    tick(); ifetch_busy = 1'b0; #1;
    checkCtl("rwait.drop", O_WAIT_LD, S_WAIT);
    check("rwait.drop.pc", pc_target, 64'h4000_0200);
    tick(); idle(); #1;
    checkCtl("rwait.run", O_IDLE, S_RUN);

    // MDU: start cycle plus 9 waiting cycles, release on the 10th.
    tick(); mdu_start = 1'b1; #1;
    checkCtl("mdu.start", O_MDU, S_RUN);
    for (int i = 0; i < 9; i++) begin
      tick(); mdu_start = 1'b0; #1;
      checkCtl("mdu.wait", O_MDU, S_MDU);
    end
    tick(); mdu_done = 1'b1; #1;
    checkCtl("mdu.done", O_MDU_DONE, S_MDU);
    tick(); idle(); mdu_done = 1'b1; #1;
    checkCtl("mdu.done_in_run", O_IDLE, S_RUN);
    check("mdu.err", 64'(err_mdu_timeout), 64'h0);

    // MDU timeout: err rises after 64 full cycles in MDU and stays.
    tick(); idle(); mdu_start = 1'b1; #1;
    checkCtl("to.start", O_MDU, S_RUN);
    for (int i = 0; i < 64; i++) begin
      tick(); mdu_start = 1'b0; #1;
      check("to.state", 64'(busy_state), 64'(S_MDU));
    end
    check("to.err_before", 64'(err_mdu_timeout), 64'h0);
    tick(); #1;
    check("to.err_set", 64'(err_mdu_timeout), 64'h1);
    checkCtl("to.still_wait", O_MDU, S_MDU);
    tick(); tick(); #1;
    check("to.err_held", 64'(err_mdu_timeout), 64'h1);
    tick(); mdu_done = 1'b1; #1;
    tick(); idle(); #1;
    checkCtl("to.exit", O_IDLE, S_RUN);
    check("to.err_sticky", 64'(err_mdu_timeout), 64'h1);

    // Reset in MDU clears state and the sticky error.
    tick(); mdu_start = 1'b1; #1;
    tick(); mdu_start = 1'b0; #1;
    checkCtl("rstmdu.in", O_MDU, S_MDU);
    tick(); reset = 1'b1; #1;
    check("rstmdu.held", 64'(outs()), 64'(O_IDLE));
    tick(); reset = 1'b0; #1;
    checkCtl("rstmdu.after", O_IDLE, S_RUN);
    check("rstmdu.err", 64'(err_mdu_timeout), 64'h0);
`ifdef PIPE_PERF_EN
    check("rstmdu.cnt", 64'(cnt_loaduse | cnt_redirect | cnt_mem_stall | cnt_mdu_stall), 64'h0);
`endif

    // Reset in REDIR_WAIT abandons the pending redirect.
    tick(); ifetch_busy = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h5000_0000; #1;
    tick(); redirect_valid = 1'b0; #1;
    checkCtl("rstwait.in", O_FETCHWT, S_WAIT);
    tick(); reset = 1'b1; #1;
    tick(); reset = 1'b0; ifetch_busy = 1'b0; #1;
    checkCtl("rstwait.after", O_IDLE, S_RUN);
    check("rstwait.pc", pc_target, 64'h0);

    // dmem_busy freezes everything; redirect taken once it drops.
    tick(); idle(); dmem_busy = 1'b1; setLoadUse(5'd5);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; #1;
    checkCtl("mem.freeze", O_FREEZE, S_RUN);
    tick(); dmem_busy = 1'b0; #1;
    checkCtl("mem.redir", O_REDIR_LD, S_RUN);
    check("mem.redir.pc", pc_target, 64'h8000_0200);

    // dmem_busy inside REDIR_WAIT holds the state and adds the freeze.
    tick(); idle(); ifetch_busy = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; #1;
    checkCtl("wmem.enter", O_REDIR_BZ, S_RUN);
    tick(); idle(); dmem_busy = 1'b1; #1;
    checkCtl("wmem.freeze", O_WAIT_MEM, S_WAIT);
    tick(); dmem_busy = 1'b0; #1;
    checkCtl("wmem.load", O_WAIT_LD, S_WAIT);
    check("wmem.pc", pc_target, 64'h8000_0300);
    tick(); #1;
    checkCtl("wmem.run", O_IDLE, S_RUN);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule : tb_pipe_ctrl
